signed_subtractor: RTL and testbench

Registered two's-complement subtractor computing diff = a - b on signed WIDTH-bit operands. The full-precision result is WIDTH+1 bits, so it never overflows. A saturated WIDTH-bit result is also provided, with overflow, negative and zero flags. The block is a single-stage datapath element with a valid qualifier, for use in arithmetic pipelines.

---
 rtl/signed_subtractor.sv | 80 ++++++++
 tb/tb_signed_subtractor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/signed_subtractor.sv
// rtl/signed_subtractor.sv - registered signed a - b with full-precision and saturated results
module signed_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   diff,
    output logic [WIDTH-1:0] diff_sat,
    output logic             ovf,
    output logic             neg,
    output logic             zero,
    output logic             out_valid
);

    // Saturation limits as raw two's-complement bit patterns.
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   diff_d;
    logic [WIDTH-1:0] diff_sat_d;
    logic             ovf_d;
    logic             neg_d;
    logic             zero_d;

    logic [WIDTH:0]   diff_q;
    logic [WIDTH-1:0] diff_sat_q;
    logic             ovf_q;
    logic             neg_q;
    logic             zero_q;
    logic             valid_q;

    // One extra bit of headroom makes the difference exact; the top two bits
    // disagree exactly when the result no longer fits in WIDTH bits.
    always_comb begin
        a_ext      = {a[WIDTH-1], a};
        b_ext      = {b[WIDTH-1], b};
        diff_d     = a_ext - b_ext;
        ovf_d      = diff_d[WIDTH] ^ diff_d[WIDTH-1];
        neg_d      = diff_d[WIDTH];
        zero_d     = (diff_d == '0);
        diff_sat_d = diff_d[WIDTH-1:0];
        if (ovf_d) begin
            diff_sat_d = diff_d[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    // Result registers load only on accepted inputs; the valid flag tracks in_valid every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_q     <= '0;
            diff_sat_q <= '0;
            ovf_q      <= 1'b0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                diff_q     <= diff_d;
                diff_sat_q <= diff_sat_d;
                ovf_q      <= ovf_d;
                neg_q      <= neg_d;
                zero_q     <= zero_d;
            end
        end
    end

    assign diff      = diff_q;
    assign diff_sat  = diff_sat_q;
    assign ovf       = ovf_q;
    assign neg       = neg_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_signed_subtractor.sv
// tb/tb_signed_subtractor.sv - directed and exhaustive self-checking bench for signed_subtractor
module tb_signed_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] diff;
    logic [3:0] diff_sat;
    logic       ovf;
    logic       neg;
    logic       zero;
    logic       out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    signed_subtractor #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .diff      (diff),
        .diff_sat  (diff_sat),
        .ovf       (ovf),
        .neg       (neg),
        .zero      (zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Packs {out_valid, diff, diff_sat, ovf, neg, zero} from hand values.
    function automatic logic [12:0] pk(logic v, int d, int s, logic o, logic n, logic z);
        logic [4:0] d5;
        logic [3:0] s4;
        d5 = d[4:0];
        s4 = s[3:0];
        return {v, d5, s4, o, n, z};
    endfunction

    function automatic logic [12:0] obs();
        return {out_valid, diff, diff_sat, ovf, neg, zero};
    endfunction

    // Applies inputs, then lets one rising edge pass and settles 1 time unit after it.
    task automatic step(logic r, logic v, int ia, int ib);
        rst_n    = r;
        in_valid = v;
        a        = ia[3:0];
        b        = ib[3:0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 3, 2);
        step(1'b0, 1'b1, 3, 2);
        n_cmp++;
        if (obs() !== pk(0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b", obs(), pk(0, 0, 0, 0, 0, 0));
        end
        step(1'b1, 1'b1, 3, 2);
        n_cmp++;
        if (obs() !== pk(1, 1, 1, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL first_after_reset 3-2: got %b want %b", obs(), pk(1, 1, 1, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        int va[4] = '{-4, 7, -5, 6};
        int vb[4] = '{1, -2, -3, 7};
        logic [12:0] ex[4];
        ex[0] = pk(1, -5, -5, 0, 1, 0);
        ex[1] = pk(1, 9, 7, 1, 0, 0);
        ex[2] = pk(1, -2, -2, 0, 1, 0);
        ex[3] = pk(1, -1, -1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, va[i], vb[i]);
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_bad++;
                $display("FAIL back_to_back[%0d] %0d-%0d: got %b want %b", i, va[i], vb[i], obs(), ex[i]);
            end
        end
    endtask

    task automatic test_extremes();
        int va[3] = '{-8, 7, -8};
        int vb[3] = '{7, -8, -8};
        logic [12:0] ex[3];
        ex[0] = pk(1, -15, -8, 1, 1, 0);
        ex[1] = pk(1, 15, 7, 1, 0, 0);
        ex[2] = pk(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, va[i], vb[i]);
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_bad++;
                $display("FAIL extremes[%0d] %0d-%0d: got %b want %b", i, va[i], vb[i], obs(), ex[i]);
            end
        end
    endtask

    task automatic test_valid_gating();
        step(1'b1, 1'b1, 5, 1);
        n_cmp++;
        if (obs() !== pk(1, 4, 4, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL gating_load 5-1: got %b want %b", obs(), pk(1, 4, 4, 0, 0, 0));
        end
        step(1'b1, 1'b0, 0, 7);
        n_cmp++;
        if (obs() !== pk(0, 4, 4, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL gating_hold: got %b want %b", obs(), pk(0, 4, 4, 0, 0, 0));
        end
        step(1'b1, 1'b0, -8, 7);
        n_cmp++;
        if (obs() !== pk(0, 4, 4, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL gating_hold2: got %b want %b", obs(), pk(0, 4, 4, 0, 0, 0));
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 1'b1, 2, 5);
        n_cmp++;
        if (obs() !== pk(1, -3, -3, 0, 1, 0)) begin
            n_bad++;
            $display("FAIL midstream_pre 2-5: got %b want %b", obs(), pk(1, -3, -3, 0, 1, 0));
        end
        step(1'b0, 1'b1, 1, 1);
        n_cmp++;
        if (obs() !== pk(0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL midstream_reset: got %b want %b", obs(), pk(0, 0, 0, 0, 0, 0));
        end
        step(1'b1, 1'b1, -3, 4);
        n_cmp++;
        if (obs() !== pk(1, -7, -7, 0, 1, 0)) begin
            n_bad++;
            $display("FAIL midstream_after -3-4: got %b want %b", obs(), pk(1, -7, -7, 0, 1, 0));
        end
    endtask

    task automatic test_sweep();
        int d, s;
        logic o;
        logic [12:0] ex;
        for (int ia = -8; ia <= 7; ia++) begin
            for (int ib = -8; ib <= 7; ib++) begin
                d  = ia - ib;
                s  = (d > 7) ? 7 : ((d < -8) ? -8 : d);
                o  = (d > 7) || (d < -8);
                ex = pk(1'b1, d, s, o, d < 0, d == 0);
                step(1'b1, 1'b1, ia, ib);
                n_cmp++;
                if (obs() !== ex) begin
                    n_bad++;
                    $display("FAIL sweep %0d-%0d: got %b want %b", ia, ib, obs(), ex);
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        test_reset();
        test_back_to_back();
        test_extremes();
        test_valid_gating();
        test_reset_midstream();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
